// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the core stall/flush controller: stall bus encodings,
// FSM state type and the divider watchdog default.
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS_W     = 6;
  localparam int DIV_TIMEOUT_DEF = 40;

  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  // bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_DIV_DONE = 2'd2
  } state_t;

  // One spare bit so the watchdog compare value always fits below saturation.
  function automatic int div_cnt_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline/divider and the stall controller.
// slave = controller side, master = pipeline side.
interface pipe_stall_ctrl_if #(parameter int STALL_W = 6);

  logic               stallreq_id;
  logic               ex_div_req;
  logic               div_ready;
  logic               exc_req;
  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_abort;
  logic               div_result_sel;
  logic               flush;
  logic               div_timeout;

  modport slave (
    input  stallreq_id, ex_div_req, div_ready, exc_req,
    output stall, div_start, div_abort, div_result_sel, flush, div_timeout
  );

  modport master (
    output stallreq_id, ex_div_req, div_ready, exc_req,
    input  stall, div_start, div_abort, div_result_sel, flush, div_timeout
  );

endinterface

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating 32-bit event counter used for stall statistics.
// Only built when STALL_PERF_EN is defined.
`ifdef STALL_PERF_EN
module stall_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != 32'hFFFF_FFFF))
      r_cnt <= r_cnt + 32'd1;
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller: load-use stalls, divider start/abort/watchdog, exception flush.
// STALL_PERF_EN adds saturating ID/EX stall-cycle counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
  parameter int STALL_W     = STALL_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]       perf_id_stall_cnt,
  output logic [31:0]       perf_ex_stall_cnt
`endif
);

  localparam int CNT_W = div_cnt_width(DIV_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [STALL_W-1:0] W_NONE = STALL_W'(STALL_NONE);
  localparam logic [STALL_W-1:0] W_ID   = STALL_W'(STALL_ID);
  localparam logic [STALL_W-1:0] W_EX   = STALL_W'(STALL_EX);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout;

  state_t             w_next;
  logic [STALL_W-1:0] w_stall;
  logic               w_start;
  logic               w_abort;
  logic               w_sel;
  logic               w_flush;
  logic               w_to_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_stall  = W_NONE;
    w_start  = 1'b0;
    w_abort  = 1'b0;
    w_sel    = 1'b0;
    w_flush  = 1'b0;
    w_to_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.exc_req) begin
          w_flush = 1'b1;
        end else if (bus.ex_div_req) begin
          w_start = 1'b1;
          w_stall = W_EX;
          w_next  = ST_DIV_WAIT;
        end else if (bus.stallreq_id) begin
          w_stall = W_ID;
        end
      end
      ST_DIV_WAIT: begin
        w_stall = W_EX;
        // The MEM-stage exception is older than the divide, so it cancels it.
        if (bus.exc_req) begin
          w_flush = 1'b1;
          w_abort = 1'b1;
          w_stall = W_NONE;
          w_next  = ST_IDLE;
        end else if (bus.div_ready) begin
          w_next  = ST_DIV_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_to_set = 1'b1;
          w_abort  = 1'b1;
          w_next   = ST_DIV_DONE;
        end
      end
      ST_DIV_DONE: begin
        // ex_div_req is still high for the retiring divide; never restart here.
        w_sel  = 1'b1;
        w_next = ST_IDLE;
        if (bus.exc_req) begin
          w_flush = 1'b1;
        end else if (bus.stallreq_id) begin
          w_stall = W_ID;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Outputs are combinational, so they must be gated by reset explicitly.
    if (rst) begin
      w_stall  = W_NONE;
      w_start  = 1'b0;
      w_abort  = 1'b0;
      w_sel    = 1'b0;
      w_flush  = 1'b0;
      w_to_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state == ST_IDLE && w_next == ST_DIV_WAIT)
      r_cnt <= '0;
    else if (r_state == ST_DIV_WAIT && r_cnt != CNT_MAX)
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_timeout <= 1'b0;
    else if (w_to_set) r_timeout <= 1'b1;
  end

  assign bus.stall          = w_stall;
  assign bus.div_start      = w_start;
  assign bus.div_abort      = w_abort;
  assign bus.div_result_sel = w_sel;
  assign bus.flush          = w_flush;
  assign bus.div_timeout    = r_timeout;

`ifdef STALL_PERF_EN
  logic w_id_evt;
  logic w_ex_evt;

  assign w_id_evt = (w_stall == W_ID);
  assign w_ex_evt = (w_stall == W_EX);

  stall_perf_cnt u_perf_id (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_id_evt),
    .o_cnt (perf_id_stall_cnt)
  );

  stall_perf_cnt u_perf_ex (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_ex_evt),
    .o_cnt (perf_ex_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; observed vector is {stall, div_start, div_abort, div_result_sel, flush}.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_stall_ctrl_if #(.STALL_W(6)) bus();

`ifdef STALL_PERF_EN
  logic [31:0] perf_id;
  logic [31:0] perf_ex;
`endif

  pipe_stall_ctrl #(.DIV_TIMEOUT(40), .STALL_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef STALL_PERF_EN
    ,
    .perf_id_stall_cnt (perf_id),
    .perf_ex_stall_cnt (perf_ex)
`endif
  );

  always #5 clk = ~clk;

  wire [9:0] obs = {bus.stall, bus.div_start, bus.div_abort, bus.div_result_sel, bus.flush};

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.stallreq_id = 1'b0;
    bus.ex_div_req  = 1'b0;
    bus.div_ready   = 1'b0;
    bus.exc_req     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stallreq_id = 1'b1;
    bus.ex_div_req  = 1'b1;
    bus.div_ready   = 1'b1;
    bus.exc_req     = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b000000_0000) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b000000_0000);
    end
    checks++;
    if (bus.div_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: got %b want 0", bus.div_timeout);
    end
`ifdef STALL_PERF_EN
    checks++;
    if (perf_id !== 32'd0 || perf_ex !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got id=%0d ex=%0d want 0/0", perf_id, perf_ex);
    end
`endif
    idle_in();
    nxt(); nxt();
    rst = 1'b0;
    #2;
    checks++;
    if (obs !== 10'b000000_0000) begin
      errors++; $display("FAIL idle_after_reset: got %b want %b", obs, 10'b000000_0000);
    end
    nxt();
  endtask

  task automatic test_load_use();
    bus.stallreq_id = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b000111_0000) begin
      errors++; $display("FAIL load_use_stall: got %b want %b", obs, 10'b000111_0000);
    end
    nxt();
    bus.stallreq_id = 1'b0;
    #2;
    checks++;
    if (obs !== 10'b000000_0000) begin
      errors++; $display("FAIL load_use_release: got %b want %b", obs, 10'b000000_0000);
    end
    nxt();
  endtask

  task automatic test_div_normal();
    bus.ex_div_req = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b001111_1000) begin
      errors++; $display("FAIL div_start_c0: got %b want %b", obs, 10'b001111_1000);
    end
    nxt();
    for (int c = 1; c <= 33; c++) begin
      bus.div_ready = (c == 33);
      #2;
      checks++;
      if (obs !== 10'b001111_0000) begin
        errors++; $display("FAIL div_wait_c%0d: got %b want %b", c, obs, 10'b001111_0000);
      end
      nxt();
    end
    bus.div_ready = 1'b0;
    #2;
    checks++;
    if (obs !== 10'b000000_0010) begin
      errors++; $display("FAIL div_done_c34: got %b want %b", obs, 10'b000000_0010);
    end
    nxt();
    bus.ex_div_req = 1'b0;
    #2;
    checks++;
    if (obs !== 10'b000000_0000) begin
      errors++; $display("FAIL div_idle_c35: got %b want %b", obs, 10'b000000_0000);
    end
`ifdef STALL_PERF_EN
    checks++;
    if (perf_ex !== 32'd34 || perf_id !== 32'd1) begin
      errors++; $display("FAIL perf_after_div: got id=%0d ex=%0d want 1/34", perf_id, perf_ex);
    end
`endif
    nxt();
  endtask

  task automatic test_exc_during_div();
    bus.ex_div_req = 1'b1;
    nxt();
    for (int c = 1; c <= 4; c++) nxt();
    bus.exc_req = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b000000_0101) begin
      errors++; $display("FAIL exc_abort: got %b want %b", obs, 10'b000000_0101);
    end
    nxt();
    bus.exc_req    = 1'b0;
    bus.ex_div_req = 1'b0;
    #2;
    checks++;
    if (obs !== 10'b000000_0000) begin
      errors++; $display("FAIL exc_back_idle: got %b want %b", obs, 10'b000000_0000);
    end
    nxt();
  endtask

  task automatic test_watchdog();
    bus.ex_div_req = 1'b1;
    nxt();
    for (int c = 1; c <= 40; c++) begin
      #2;
      if (c == 39) begin
        checks++;
        if (obs !== 10'b001111_0000) begin
          errors++; $display("FAIL wd_c39: got %b want %b", obs, 10'b001111_0000);
        end
      end
      if (c == 40) begin
        checks++;
        if (obs !== 10'b001111_0100 || bus.div_timeout !== 1'b0) begin
          errors++; $display("FAIL wd_c40: got %b/%b want %b/0", obs, bus.div_timeout, 10'b001111_0100);
        end
      end
      nxt();
    end
    #2;
    checks++;
    if (obs !== 10'b000000_0010 || bus.div_timeout !== 1'b1) begin
      errors++; $display("FAIL wd_done: got %b/%b want %b/1", obs, bus.div_timeout, 10'b000000_0010);
    end
    nxt();
    bus.ex_div_req = 1'b0;
    for (int c = 0; c < 5; c++) nxt();
    #2;
    checks++;
    if (bus.div_timeout !== 1'b1) begin
      errors++; $display("FAIL wd_sticky: got %b want 1", bus.div_timeout);
    end
    nxt();
  endtask

  task automatic test_priority();
    bus.exc_req = 1'b1; bus.ex_div_req = 1'b1; bus.stallreq_id = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b000000_0001) begin
      errors++; $display("FAIL prio_collision: got %b want %b", obs, 10'b000000_0001);
    end
    nxt();
    bus.exc_req = 1'b0; bus.stallreq_id = 1'b0;
    nxt();
    bus.div_ready = 1'b1;
    nxt();
    bus.div_ready = 1'b0; bus.stallreq_id = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b000111_0010) begin
      errors++; $display("FAIL done_with_id: got %b want %b", obs, 10'b000111_0010);
    end
    nxt();
    bus.stallreq_id = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.ex_div_req = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b001111_1000) begin
      errors++; $display("FAIL b2b_start: got %b want %b", obs, 10'b001111_1000);
    end
    nxt();
    bus.div_ready = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b001111_0000) begin
      errors++; $display("FAIL b2b_ready: got %b want %b", obs, 10'b001111_0000);
    end
    nxt();
    bus.div_ready = 1'b0; bus.exc_req = 1'b1; bus.stallreq_id = 1'b1;
    #2;
    checks++;
    if (obs !== 10'b000000_0011) begin
      errors++; $display("FAIL done_exc_over_id: got %b want %b", obs, 10'b000000_0011);
    end
    nxt();
    idle_in();
    nxt();
  endtask

  task automatic test_reset_mid_div();
    bus.ex_div_req = 1'b1;
    nxt();
    for (int c = 1; c <= 3; c++) nxt();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b000000_0000 || bus.div_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_mid_div: got %b/%b want %b/0", obs, bus.div_timeout, 10'b000000_0000);
    end
`ifdef STALL_PERF_EN
    checks++;
    if (perf_id !== 32'd0 || perf_ex !== 32'd0) begin
      errors++; $display("FAIL perf_mid_reset: got id=%0d ex=%0d want 0/0", perf_id, perf_ex);
    end
`endif
    nxt();
    idle_in();
    nxt();
    rst = 1'b0;
    #2;
    checks++;
    if (obs !== 10'b000000_0000) begin
      errors++; $display("FAIL idle_post_reset: got %b want %b", obs, 10'b000000_0000);
    end
    nxt();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_load_use();
    test_div_normal();
    test_exc_during_div();
    test_watchdog();
    test_priority();
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage core; replaces the constant-zero stall generator.
- Merges the ID load-use request with multi-cycle divide sequencing in EX, and drives the shared 6-bit stall bus to IF/ID/EX/MEM/WB.
- Owns the start/abort handshake of the iterative divider and the exception flush pulse.

Parameters:
- DIV_TIMEOUT, 40, watchdog limit in cycles for divider completion.
- STALL_W, 6, stall bus width (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- stallreq_id  in  1  load-use hazard detected in ID
- ex_div_req  in  1  EX holds a div/divu instruction; held while the instruction stays in EX
- div_ready  in  1  divider result valid, single-cycle pulse
- exc_req  in  1  exception/eret committed in MEM
- stall  out  STALL_W  per-stage hold vector
- div_start  out  1  start pulse to divider
- div_abort  out  1  cancel in-flight divide
- div_result_sel  out  1  EX selects the latched divider result
- flush  out  1  flush IF/ID, ID/EX and EX/MEM registers
- div_timeout  out  1  sticky watchdog error flag

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- State and outputs in reset:
  - rst high: state=IDLE, counter=0, div_timeout=0.
  - All outputs are forced 0 while rst is high, including the combinational ones.
- Output timing: stall, div_start, div_abort, flush and div_result_sel are combinational from state and inputs, so they act in the same cycle. State, counter and div_timeout are registered.
- Stall encodings:
  - NONE = 000000
  - ID = 000111 (hold PC, IF/ID, ID/EX input; bubble into EX)
  - EX = 001111 (bubble into MEM)
- FSM states: IDLE, DIV_WAIT, DIV_DONE.
- IDLE:
  - Priority is exc_req > ex_div_req > stallreq_id.
  - exc_req: flush=1, stall=NONE, stay IDLE.
  - ex_div_req: div_start=1, stall=EX, counter<=0, next DIV_WAIT.
  - stallreq_id only: stall=ID, stay IDLE.
  - Otherwise stall=NONE.
- DIV_WAIT:
  - stall=EX; counter increments each cycle.
  - exc_req: flush=1, div_abort=1, stall=NONE, next IDLE. The MEM instruction is older, so the divide is cancelled.
  - div_ready: next DIV_DONE.
  - counter==DIV_TIMEOUT-1 with no div_ready: div_timeout<=1 (sticky until reset), div_abort=1, next DIV_DONE.
  - exc_req and div_ready in the same cycle: exc_req wins.
- DIV_DONE (exactly 1 cycle):
  - div_result_sel=1; EX advances, so stall is never EX here.
  - ex_div_req is still high in this cycle and must NOT generate div_start.
  - stallreq_id gives stall=ID, otherwise NONE.
  - exc_req: flush=1 and stall=NONE, overriding stallreq_id.
  - Next IDLE.
- Counter: $clog2(DIV_TIMEOUT)+1 bits; saturates and never wraps; cleared on entry to DIV_WAIT.
- Back-to-back divides: a second div arriving in EX the cycle after DIV_DONE starts normally from IDLE.
- div_start and flush are never asserted in the same cycle.
- Asynchronous reset mid-divide returns to IDLE immediately; no div_abort pulse is emitted, because the divider shares rst.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - Adds outputs perf_id_stall_cnt[31:0] and perf_ex_stall_cnt[31:0].
  - These increment in each cycle that stall equals ID or EX, respectively.
  - Saturate at 32'hFFFFFFFF; cleared by rst.
- Undefined: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared defines header holds:
  - StallBus width (6)
  - stall encodings STALL_NONE, STALL_ID, STALL_EX
  - FSM state constants (2-bit)
  - DIV_TIMEOUT default
- One sub-module: stall_perf_cnt, a saturating 32-bit event counter instantiated twice, present only under STALL_PERF_EN.

Test Plan:
- Load-use: stallreq_id=1 for 1 cycle in IDLE -> stall=000111 that cycle, 000000 the next; div_start never asserted.
- Divide normal: ex_div_req=1 at cycle 0, div_ready at cycle 33 -> div_start=1 only at cycle 0; stall=001111 for cycles 0-33; DIV_DONE at cycle 34 with div_result_sel=1 and stall=000000; IDLE at 35.
- Exception during divide: exc_req at the 5th DIV_WAIT cycle -> flush=1, div_abort=1, stall=000000 that cycle; next state IDLE; no div_result_sel.
- Watchdog: ex_div_req=1, div_ready held 0 -> at DIV_WAIT cycle 40 div_abort=1 and div_timeout=1; it stays 1 until rst.
- Priority collision: exc_req=1, ex_div_req=1 and stallreq_id=1 together in IDLE -> flush=1, div_start=0, stall=000000; a following DIV_DONE with stallreq_id=1 gives stall=000111.
- Reset mid-divide: rst asserted asynchronously in DIV_WAIT -> all outputs 0 immediately. With STALL_PERF_EN defined, the perf counters read 0 after reset and count 34 EX stall cycles after the divide scenario.
